wb_arbiter: RTL and testbench

- Write-back arbiter that sits directly upstream of the 32x64 LEGv8 register file and drives its single write port (wa3/wd3/we3).
- Merges two producers into that port: ALU results, which arrive in-order and cannot stall, and load returns from memory, which have variable latency and use a valid/ready handshake.
- Buffers load returns in a small FIFO, enforces write-after-write ordering, suppresses writes to XZR (X31), and exports a pending-register mask for the hazard unit.

---
 rtl/wb_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter driving the register file's single write port: in-order ALU
// results take priority, load returns are buffered in a small FIFO with WAW kill.
module wb_arbiter #(
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_wa,
  input  logic [DW-1:0]                alu_wd,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_wa,
  input  logic [DW-1:0]                mem_wd,
  output logic                         we3,
  output logic [AW-1:0]                wa3,
  output logic [DW-1:0]                wd3,
  output logic [(2**AW)-1:0]           pending,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NR = 2 ** AW;

  logic          occ_q  [DEPTH];
  logic          kill_q [DEPTH];
  logic [AW-1:0] wa_q   [DEPTH];
  logic [DW-1:0] wd_q   [DEPTH];
  logic [PW-1:0] rd_q, wr_q;

  logic          occ_n  [DEPTH];
  logic          kill_n [DEPTH];
  logic [AW-1:0] wa_n   [DEPTH];
  logic [DW-1:0] wd_n   [DEPTH];
  logic [PW-1:0] rd_n, wr_n;
  logic [CW-1:0] count_n;
  logic          we_n, ready_n;
  logic [AW-1:0] wa3_n;
  logic [DW-1:0] wd3_n;
  logic [NR-1:0] pending_n;

  logic alu_req, push, pop;

  // Next FIFO state, write-port selection and derived status, all from registered state
  always_comb begin
    occ_n     = occ_q;
    kill_n    = kill_q;
    wa_n      = wa_q;
    wd_n      = wd_q;
    rd_n      = rd_q;
    wr_n      = wr_q;
    we_n      = 1'b0;
    wa3_n     = wa3;
    wd3_n     = wd3;
    pending_n = '0;

    alu_req = alu_valid && (alu_wa != '1);
    push    = mem_valid && mem_ready && (mem_wa != '1);
    pop     = !alu_req && (fifo_count != '0);

    // The ALU result is younger than any buffered load to the same register
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (alu_req && occ_q[i] && (wa_q[i] == alu_wa)) kill_n[i] = 1'b1;
    end

    if (alu_req) begin
      we_n  = 1'b1;
      wa3_n = alu_wa;
      wd3_n = alu_wd;
    end else if (pop) begin
      occ_n[rd_q] = 1'b0;
      rd_n        = rd_q + PW'(1);
      if (!kill_q[rd_q]) begin
        we_n  = 1'b1;
        wa3_n = wa_q[rd_q];
        wd3_n = wd_q[rd_q];
      end
    end

    // Pushed after the kill scan, so a same-cycle matching ALU write leaves it live
    if (push) begin
      occ_n[wr_q]  = 1'b1;
      kill_n[wr_q] = 1'b0;
      wa_n[wr_q]   = mem_wa;
      wd_n[wr_q]   = mem_wd;
      wr_n         = wr_q + PW'(1);
    end

    count_n = fifo_count + CW'(push) - CW'(pop);
    ready_n = count_n < CW'(DEPTH);

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (occ_n[i] && !kill_n[i]) pending_n[wa_n[i]] = 1'b1;
    end
    pending_n[NR-1] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        occ_q[i]  <= 1'b0;
        kill_q[i] <= 1'b0;
        wa_q[i]   <= '0;
        wd_q[i]   <= '0;
      end
      rd_q       <= '0;
      wr_q       <= '0;
      fifo_count <= '0;
      mem_ready  <= 1'b1;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      pending    <= '0;
    end else begin
      occ_q      <= occ_n;
      kill_q     <= kill_n;
      wa_q       <= wa_n;
      wd_q       <= wd_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      fifo_count <= count_n;
      mem_ready  <= ready_n;
      we3        <= we_n;
      wa3        <= wa3_n;
      wd3        <= wd3_n;
      pending    <= pending_n;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [63:0] alu_wd;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_wa;
  logic [63:0] mem_wd;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DW(64), .AW(5), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
    bit          kill;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [63:0] exp_wd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] m = '0;
    foreach (q[i]) if (!q[i].kill && q[i].wa != 5'd31) m[q[i].wa] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, "/we3"}, 64'(we3), 64'(exp_we));
    chk({ph, "/wa3"}, 64'(wa3), 64'(exp_wa));
    chk({ph, "/wd3"}, wd3, exp_wd);
    chk({ph, "/pending"}, 64'(pending), 64'(model_pending()));
    chk({ph, "/fifo_count"}, 64'(fifo_count), 64'(q.size()));
    chk({ph, "/mem_ready"}, 64'(mem_ready), 64'(q.size() < 4));
  endtask

  // One clock: apply inputs at the falling edge, advance the model, check at the next falling edge
  task automatic cycle(input string ph, input logic av, input logic [4:0] aw, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mw, input logic [63:0] md);
    bit ready, acc, alu_req;
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    mem_valid = mv; mem_wa = mw; mem_wd = md;
    ready   = q.size() < 4;
    acc     = mv && ready;
    alu_req = av && (aw != 5'd31);
    exp_we  = 1'b0;
    if (alu_req) begin
      foreach (q[i]) if (q[i].wa == aw) q[i].kill = 1'b1;
      exp_we = 1'b1; exp_wa = aw; exp_wd = ad;
    end else if (q.size() > 0) begin
      ent_t h = q.pop_front();
      if (!h.kill) begin
        exp_we = 1'b1; exp_wa = h.wa; exp_wd = h.wd;
      end
    end
    if (acc && mw != 5'd31) q.push_back('{wa: mw, wd: md, kill: 1'b0});
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic do_reset(input string ph);
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 64'hDEAD;
    mem_valid = 1'b1; mem_wa = 5'd4; mem_wd = 64'hBEEF;
    q.delete();
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    #1;
    check_outputs({ph, "/assert"});
    repeat (2) @(negedge clk);
    check_outputs({ph, "/held"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    @(negedge clk);
    do_reset("reset");

    // ALU write then idle: wa3/wd3 hold
    cycle("alu", 1, 5'd5, 64'h1234, 0, 0, 0);
    cycle("alu_idle", 0, 5'd0, 64'h0, 0, 0, 0);

    // Fill the FIFO under constant ALU pressure, then drain in order
    for (int i = 0; i < 4; i++)
      cycle("fill", 1, 5'd10, 64'(i), 1, 5'(i + 1), 64'hA + 64'(i));
    cycle("full", 1, 5'd10, 64'h55, 1, 5'd12, 64'hEE);
    for (int i = 0; i < 5; i++)
      cycle("drain", 0, 5'd0, 64'h0, 0, 0, 0);

    // WAW: a younger ALU write kills the buffered load
    cycle("waw_push", 1, 5'd10, 64'h0, 1, 5'd7, 64'h77);
    cycle("waw_alu", 1, 5'd7, 64'h99, 0, 0, 0);
    cycle("waw_pop", 0, 5'd0, 64'h0, 0, 0, 0);
    cycle("waw_idle", 0, 5'd0, 64'h0, 0, 0, 0);

    // XZR: ALU to X31 lets the FIFO pop; load to X31 is swallowed
    cycle("xzr_push", 1, 5'd10, 64'h1, 1, 5'd3, 64'h33);
    cycle("xzr_alu", 1, 5'd31, 64'hFF, 0, 0, 0);
    cycle("xzr_load", 0, 5'd0, 64'h0, 1, 5'd31, 64'h5);
    cycle("xzr_idle", 0, 5'd0, 64'h0, 0, 0, 0);

    // Same-cycle ALU write and load push to X9: load survives and writes second
    cycle("same9", 1, 5'd9, 64'h1, 1, 5'd9, 64'h2);
    cycle("same9_pop", 0, 5'd0, 64'h0, 0, 0, 0);
    cycle("same9_idle", 0, 5'd0, 64'h0, 0, 0, 0);

    // Random traffic, with a mid-stream reset that discards buffered loads
    for (int n = 0; n < 2000; n++) begin
      logic av, mv;
      logic [4:0] aw, mw;
      if (n == 1000) do_reset("mid_reset");
      av = ($urandom % 3) != 0;
      mv = ($urandom % 2) != 0;
      aw = (($urandom % 8) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      mw = (($urandom % 8) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cycle("rand", av, aw, {$urandom, $urandom}, mv, mw, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
